// File: rtl/piano_pkg.sv
// Shared constants, receiver state type and scan-code-to-note map for the PS/2 key decoder.
package piano_pkg;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;
   localparam int         NOTE_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_e;

   // Returns {mapped, note index}; unmapped codes return all zeros.
   function automatic logic [NOTE_W:0] note_lookup(input logic [7:0] code);
      logic [NOTE_W:0] r;
      r = '0;
      case (code)
         8'h1C:   r = {1'b1, 4'd0};
         8'h1B:   r = {1'b1, 4'd1};
         8'h23:   r = {1'b1, 4'd2};
         8'h2B:   r = {1'b1, 4'd3};
         8'h34:   r = {1'b1, 4'd4};
         8'h33:   r = {1'b1, 4'd5};
         8'h3B:   r = {1'b1, 4'd6};
         8'h42:   r = {1'b1, 4'd7};
         8'h1D:   r = {1'b1, 4'd8};
         8'h24:   r = {1'b1, 4'd9};
         8'h2C:   r = {1'b1, 4'd10};
         8'h35:   r = {1'b1, 4'd11};
         8'h3C:   r = {1'b1, 4'd12};
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: input synchronisers, falling-edge detect, frame FSM and inter-edge timeout.
// Parity is enforced only when PS2_PARITY_CHECK_EN is defined.
//
//   state     | meaning
//   ----------+--------------------------------------------------
//   ST_IDLE   | waiting for a falling edge with data 0 (start bit)
//   ST_DATA   | shifting in 8 data bits, LSB first
//   ST_PARITY | consuming the parity bit
//   ST_STOP   | checking the stop bit, then byte_rdy or frame_err
module ps2_rx_frame
   import piano_pkg::*;
#(
   parameter int CLK_FREQ    = 5000000,
   parameter int TIMEOUT_US  = 2000,
   parameter int SYNC_STAGES = 2
) (
   input  logic       CLK,
   input  logic       nCLR,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       byte_rdy,
   output logic       frame_err
);

   localparam int TIMEOUT_CYCLES = CLK_FREQ / 1000000 * TIMEOUT_US;
   localparam int TMR_W          = $clog2(TIMEOUT_CYCLES + 1);

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] dat_sync;
   logic                   clk_prev;
   logic                   clk_s;
   logic                   dat_s;
   logic                   fall;
   logic                   timeout;
   logic                   frame_ok;
   rx_state_e              state;
   logic [2:0]             bit_cnt;
   logic [7:0]             shreg;
   logic [TMR_W-1:0]       tmr;
`ifdef PS2_PARITY_CHECK_EN
   logic                   parity;
`endif

   assign clk_s   = clk_sync[SYNC_STAGES-1];
   assign dat_s   = dat_sync[SYNC_STAGES-1];
   assign fall    = clk_prev & ~clk_s;
   assign rx_byte = shreg;

   // A fall in the same cycle as terminal count keeps the frame alive.
   assign timeout = (state != ST_IDLE) && (tmr == '0) && !fall;

`ifdef PS2_PARITY_CHECK_EN
   assign frame_ok = dat_s & (^shreg ^ parity);
`else
   assign frame_ok = dat_s;
`endif

   always_ff @(posedge CLK or negedge nCLR) begin
      if (!nCLR) begin
         clk_sync  <= '1;
         dat_sync  <= '1;
         clk_prev  <= 1'b1;
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         tmr       <= '0;
         byte_rdy  <= 1'b0;
         frame_err <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
         parity    <= 1'b0;
`endif
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
         dat_sync  <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
         clk_prev  <= clk_s;
         byte_rdy  <= 1'b0;
         frame_err <= 1'b0;

         if (fall) begin
            tmr <= TMR_W'(TIMEOUT_CYCLES);
         end else if (state != ST_IDLE && tmr != '0) begin
            tmr <= tmr - TMR_W'(1);
         end

         if (timeout) begin
            frame_err <= 1'b1;
            state     <= ST_IDLE;
         end else if (fall) begin
            case (state)
               ST_IDLE: begin
                  if (!dat_s) begin
                     state   <= ST_DATA;
                     bit_cnt <= '0;
                  end
               end
               ST_DATA: begin
                  shreg   <= {dat_s, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= ST_PARITY;
               end
               ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                  parity <= dat_s;
`endif
                  state  <= ST_STOP;
               end
               ST_STOP: begin
                  if (frame_ok) byte_rdy  <= 1'b1;
                  else          frame_err <= 1'b1;
                  state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 key decoder top: strips E0/F0 prefixes, emits make/break events and holds the last mapped note.
// Optional strict parity checking is enabled with PS2_PARITY_CHECK_EN.
module ps2_key_decoder
   import piano_pkg::*;
#(
   parameter int CLK_FREQ    = 5000000,
   parameter int TIMEOUT_US  = 2000,
   parameter int SYNC_STAGES = 2
) (
   input  logic              CLK,
   input  logic              nCLR,
   input  logic              ps2_clk,
   input  logic              ps2_data,
   output logic [7:0]        key_code,
   output logic              key_ext,
   output logic              key_make,
   output logic              key_break,
   output logic              frame_err,
   output logic [NOTE_W-1:0] note,
   output logic              note_valid
);

   logic [7:0]        rx_byte;
   logic              byte_rdy;
   logic              rx_err;
   logic              ext_pend;
   logic              brk_pend;
   logic [NOTE_W:0]   lut;
   logic              mapped;
   logic [NOTE_W-1:0] lut_idx;

   ps2_rx_frame #(
      .CLK_FREQ   (CLK_FREQ),
      .TIMEOUT_US (TIMEOUT_US),
      .SYNC_STAGES(SYNC_STAGES)
   ) u_rx (
      .CLK      (CLK),
      .nCLR     (nCLR),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .rx_byte  (rx_byte),
      .byte_rdy (byte_rdy),
      .frame_err(rx_err)
   );

   assign frame_err = rx_err;
   assign lut       = note_lookup(rx_byte);
   assign lut_idx   = lut[NOTE_W-1:0];
   // Extended codes never drive the note map.
   assign mapped    = lut[NOTE_W] & ~ext_pend;

   always_ff @(posedge CLK or negedge nCLR) begin
      if (!nCLR) begin
         key_code   <= '0;
         key_ext    <= 1'b0;
         key_make   <= 1'b0;
         key_break  <= 1'b0;
         note       <= '0;
         note_valid <= 1'b0;
         ext_pend   <= 1'b0;
         brk_pend   <= 1'b0;
      end else begin
         key_make  <= 1'b0;
         key_break <= 1'b0;
         if (rx_err) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
         end else if (byte_rdy) begin
            if (rx_byte == PS2_EXT) begin
               ext_pend <= 1'b1;
            end else if (rx_byte == PS2_BRK) begin
               brk_pend <= 1'b1;
            end else begin
               key_code <= rx_byte;
               key_ext  <= ext_pend;
               if (brk_pend) begin
                  key_break <= 1'b1;
                  if (mapped && note_valid && lut_idx == note) note_valid <= 1'b0;
               end else begin
                  key_make <= 1'b1;
                  if (mapped) begin
                     note       <= lut_idx;
                     note_valid <= 1'b1;
                  end
               end
               ext_pend <= 1'b0;
               brk_pend <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed vector table, timeout/reset/glitch sequences,
// then random frames checked against a byte-level reference model.
module tb_ps2_key_decoder;

   localparam int HALF = 4;

   logic       CLK = 1'b0;
   logic       nCLR = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] key_code;
   logic       key_ext;
   logic       key_make;
   logic       key_break;
   logic       frame_err;
   logic [3:0] note;
   logic       note_valid;

   ps2_key_decoder dut (
      .CLK       (CLK),
      .nCLR      (nCLR),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .key_code  (key_code),
      .key_ext   (key_ext),
      .key_make  (key_make),
      .key_break (key_break),
      .frame_err (frame_err),
      .note      (note),
      .note_valid(note_valid)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   // event monitor
   int         n_make = 0;
   int         n_brk  = 0;
   int         n_err  = 0;
   logic [7:0] ev_code = '0;
   logic       ev_ext = 1'b0;

   always @(negedge CLK) begin
      if (nCLR) begin
         if (key_make)  n_make <= n_make + 1;
         if (key_break) n_brk  <= n_brk + 1;
         if (frame_err) n_err  <= n_err + 1;
         if (key_make || key_break) begin
            ev_code <= key_code;
            ev_ext  <= key_ext;
         end
      end
   end

   int s_make, s_brk, s_err;

   // reference model state
   logic [7:0] note_codes [13] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B,
                                   8'h42, 8'h1D, 8'h24, 8'h2C, 8'h35, 8'h3C};
   bit         m_ext, m_brk, m_nv, m_kext;
   int         m_note;
   logic [7:0] m_code;
   int         e_mk, e_bk, e_er;

   typedef struct {
      logic [7:0] code;
      bit         pb;
      bit         sb;
      int         e_mk;
      int         e_bk;
      int         e_er;
      logic [7:0] e_code;
      bit         e_ext;
      int         e_note;
      bit         e_nv;
   } vec_t;

   localparam int NV = 17;
   vec_t vecs [NV];

   function automatic int note_of(input logic [7:0] c);
      for (int k = 0; k < 13; k++) if (note_codes[k] == c) return k;
      return -1;
   endfunction

   function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit pb, input bit sb);
      logic p;
      p = ~^b;
      if (pb) p = ~p;
      return {~sb, p, b, 1'b0};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_ext = 0; m_brk = 0; m_nv = 0; m_note = 0; m_code = '0; m_kext = 0;
   endtask

   task automatic model_frame(input logic [7:0] b, input bit pb, input bit sb);
      bit good;
      int idx;
      e_mk = 0; e_bk = 0; e_er = 0;
      good = !sb;
`ifdef PS2_PARITY_CHECK_EN
      if (pb) good = 0;
`endif
      idx = note_of(b);
      if (!good) begin
         e_er = 1; m_ext = 0; m_brk = 0;
      end else if (b == 8'hE0) begin
         m_ext = 1;
      end else if (b == 8'hF0) begin
         m_brk = 1;
      end else begin
         m_code = b;
         m_kext = m_ext;
         if (m_brk) begin
            e_bk = 1;
            if (!m_ext && idx >= 0 && m_nv && m_note == idx) m_nv = 0;
         end else begin
            e_mk = 1;
            if (!m_ext && idx >= 0) begin
               m_note = idx;
               m_nv   = 1;
            end
         end
         m_ext = 0; m_brk = 0;
      end
   endtask

   task automatic send_bits(input logic [10:0] bits, input int nbits, input int stall_at,
                            input int stall_cyc);
      for (int i = 0; i < nbits; i++) begin
         if (i == stall_at) repeat (stall_cyc) @(posedge CLK);
         ps2_data = bits[i];
         repeat (HALF) @(posedge CLK);
         ps2_clk = 1'b0;
         repeat (HALF) @(posedge CLK);
         ps2_clk = 1'b1;
      end
      repeat (HALF) @(posedge CLK);
      ps2_data = 1'b1;
   endtask

   task automatic snap();
      s_make = n_make; s_brk = n_brk; s_err = n_err;
   endtask

   task automatic settle(input int cyc);
      repeat (cyc) @(posedge CLK);
      @(negedge CLK);
      #1;
   endtask

   task automatic xfer(input logic [7:0] b, input bit pb, input bit sb, input int stall_at,
                       input int stall_cyc);
      snap();
      send_bits(mk_frame(b, pb, sb), 11, stall_at, stall_cyc);
      settle(6);
   endtask

   task automatic run_checked(input string name, input logic [7:0] b, input bit pb, input bit sb,
                              input int stall_at, input int stall_cyc);
      xfer(b, pb, sb, stall_at, stall_cyc);
      model_frame(b, pb, sb);
      chk({name, " make"}, n_make - s_make, e_mk);
      chk({name, " break"}, n_brk - s_brk, e_bk);
      chk({name, " err"}, n_err - s_err, e_er);
      if (e_mk + e_bk > 0) begin
         chk({name, " code"}, int'(ev_code), int'(m_code));
         chk({name, " ext"}, int'(ev_ext), int'(m_kext));
      end
      chk({name, " note"}, int'(note), m_note);
      chk({name, " note_valid"}, int'(note_valid), int'(m_nv));
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b, last_mapped;
      int r;
      string nm;

      vecs[0]  = '{8'h1C, 0, 0, 1, 0, 0, 8'h1C, 0, 0, 1};
      vecs[1]  = '{8'hF0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 1};
      vecs[2]  = '{8'h1C, 0, 0, 0, 1, 0, 8'h1C, 0, 0, 0};
      vecs[3]  = '{8'h1C, 0, 0, 1, 0, 0, 8'h1C, 0, 0, 1};
      vecs[4]  = '{8'h1D, 0, 0, 1, 0, 0, 8'h1D, 0, 8, 1};
      vecs[5]  = '{8'hF0, 0, 0, 0, 0, 0, 8'h00, 0, 8, 1};
      vecs[6]  = '{8'h1C, 0, 0, 0, 1, 0, 8'h1C, 0, 8, 1};
      vecs[7]  = '{8'hE0, 0, 0, 0, 0, 0, 8'h00, 0, 8, 1};
      vecs[8]  = '{8'h75, 0, 0, 1, 0, 0, 8'h75, 1, 8, 1};
      vecs[9]  = '{8'hF0, 0, 0, 0, 0, 0, 8'h00, 0, 8, 1};
      vecs[10] = '{8'h1C, 0, 1, 0, 0, 1, 8'h00, 0, 8, 1};
`ifdef PS2_PARITY_CHECK_EN
      vecs[11] = '{8'h1C, 1, 0, 0, 0, 1, 8'h00, 0, 8, 1};
`else
      vecs[11] = '{8'h1C, 1, 0, 1, 0, 0, 8'h1C, 0, 0, 1};
`endif
      vecs[12] = '{8'h1C, 0, 0, 1, 0, 0, 8'h1C, 0, 0, 1};
      vecs[13] = '{8'hE0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 1};
      vecs[14] = '{8'hF0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 1};
      vecs[15] = '{8'h75, 0, 0, 0, 1, 0, 8'h75, 1, 0, 1};
      vecs[16] = '{8'h5A, 0, 0, 1, 0, 0, 8'h5A, 0, 0, 1};

      model_reset();
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("reset outputs", int'({key_code, key_ext, key_make, key_break, frame_err, note, note_valid}), 0);
      #2 nCLR = 1'b1;
      settle(4);

      for (int i = 0; i < NV; i++) begin
         xfer(vecs[i].code, vecs[i].pb, vecs[i].sb, -1, 0);
         model_frame(vecs[i].code, vecs[i].pb, vecs[i].sb);
         nm = $sformatf("vec%0d", i);
         chk({nm, " make"}, n_make - s_make, vecs[i].e_mk);
         chk({nm, " break"}, n_brk - s_brk, vecs[i].e_bk);
         chk({nm, " err"}, n_err - s_err, vecs[i].e_er);
         if (vecs[i].e_mk + vecs[i].e_bk > 0) begin
            chk({nm, " code"}, int'(ev_code), int'(vecs[i].e_code));
            chk({nm, " ext"}, int'(ev_ext), int'(vecs[i].e_ext));
         end
         chk({nm, " note"}, int'(note), vecs[i].e_note);
         chk({nm, " note_valid"}, int'(note_valid), int'(vecs[i].e_nv));
      end

      // glitch in idle: fall with data high is ignored
      snap();
      ps2_data = 1'b1;
      repeat (HALF) @(posedge CLK);
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge CLK);
      ps2_clk = 1'b1;
      settle(8);
      chk("glitch err", n_err - s_err, 0);
      run_checked("after glitch", 8'h3B, 0, 0, -1, 0);

      // timeout after 4 data bits
      snap();
      send_bits(mk_frame(8'h23, 0, 0), 5, -1, 0);
      settle(10500);
      chk("timeout err", n_err - s_err, 1);
      chk("timeout make", n_make - s_make, 0);
      m_ext = 0; m_brk = 0;
      run_checked("post-timeout 23", 8'h23, 0, 0, -1, 0);
      chk("post-timeout note", int'(note), 2);

      // gap just under the timeout keeps the frame alive
      run_checked("long gap 33", 8'h33, 0, 0, 4, 9900);

      // reset mid-frame
      snap();
      send_bits(mk_frame(8'h42, 0, 0), 4, -1, 0);
      @(posedge CLK);
      #2 nCLR = 1'b0;
      @(negedge CLK);
      #1;
      chk("mid-frame reset outputs",
          int'({key_code, key_ext, key_make, key_break, frame_err, note, note_valid}), 0);
      repeat (3) @(posedge CLK);
      #2 nCLR = 1'b1;
      model_reset();
      settle(4);
      run_checked("post-reset 1B", 8'h1B, 0, 0, -1, 0);
      chk("post-reset note", int'(note), 1);

      // random frames
      last_mapped = 8'h1C;
      for (int i = 0; i < 80; i++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2, 3, 4: b = note_codes[$urandom_range(0, 12)];
            5:             b = 8'hE0;
            6:             b = 8'hF0;
            8:             b = last_mapped;
            default:       b = 8'($urandom_range(0, 255));
         endcase
         if (note_of(b) >= 0) last_mapped = b;
         run_checked($sformatf("rnd%0d", i), b, ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 15) == 0), -1, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
